ray_word_assembler: RTL and testbench

// Sits directly downstream of the ray-input FIFO. Pops WORD_WIDTH-bit words (first-word-fall-through
// NOT supported: FIFO dout is registered, valid 1 cycle after rd_en) and packs WORDS_PER_RAY

---
 rtl/ray_word_assembler.sv | 126 ++++++++++++
 tb/tb_ray_word_assembler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_word_assembler.sv
// ray_word_assembler
// Pops WORDS_PER_RAY words from a registered-output FIFO (data arrives one
// cycle after rd_en) and packs them into one ray record. The record is shown
// on a valid/ready port and tagged with a sequential ray id.
//
// Handshake: ray_valid rises on the edge that captures the last word and stays
// high, with ray_data/ray_id stable, until a posedge where ray_valid & ray_ready.
// That edge is the transfer. ray_ready has no effect while no record is held.
module ray_word_assembler #(
    parameter int WORD_WIDTH    = 32,
    parameter int WORDS_PER_RAY = 6,
    parameter int ID_WIDTH      = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                fifo_empty,
    output logic                                fifo_rd_en,
    input  logic [WORD_WIDTH-1:0]               fifo_dout,
    output logic                                ray_valid,
    input  logic                                ray_ready,
    output logic [WORDS_PER_RAY*WORD_WIDTH-1:0] ray_data,
    output logic [ID_WIDTH-1:0]                 ray_id,
    output logic                                busy
);

    // The counters must be able to hold WORDS_PER_RAY itself: issue_cnt
    // reaches it after the last read, and cap_idx does after the last capture.
    localparam int CNT_W = $clog2(WORDS_PER_RAY + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_RAY - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_RAY);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    issue_cnt_next;
    logic [CNT_W-1:0]    cap_idx;
    logic [CNT_W-1:0]    cap_idx_next;
    logic [ID_WIDTH-1:0] ray_id_next;
    logic                pending;
    logic [WORD_WIDTH-1:0] slots [WORDS_PER_RAY];

    // Next-state logic, read strobe and counter updates.
    always_comb begin
        state_next     = state;
        issue_cnt_next = issue_cnt;
        cap_idx_next   = cap_idx;
        ray_id_next    = ray_id;
        fifo_rd_en     = 1'b0;
        case (state)
            COLLECT: begin
                // Gated by reset so the FIFO never sees a pop while the
                // block is being reset.
                fifo_rd_en = reset & ~fifo_empty & (issue_cnt < FULL_CNT);
                if (fifo_rd_en) begin
                    issue_cnt_next = issue_cnt + 1'b1;
                end
                if (pending) begin
                    cap_idx_next = cap_idx + 1'b1;
                    if (cap_idx == LAST_IDX) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ray_ready) begin
                    state_next     = COLLECT;
                    issue_cnt_next = '0;
                    cap_idx_next   = '0;
                    ray_id_next    = ray_id + 1'b1;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // State, counters and the read-in-flight flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= COLLECT;
            issue_cnt <= '0;
            cap_idx   <= '0;
            ray_id    <= '0;
            pending   <= 1'b0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_cnt_next;
            cap_idx   <= cap_idx_next;
            ray_id    <= ray_id_next;
            pending   <= fifo_rd_en;
        end
    end

    // Word slots: the word returned for the previous read lands in slot cap_idx.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < WORDS_PER_RAY; k++) begin
                slots[k] <= '0;
            end
        end else begin
            for (int k = 0; k < WORDS_PER_RAY; k++) begin
                if (pending && (cap_idx == CNT_W'(k))) begin
                    slots[k] <= fifo_dout;
                end
            end
        end
    end

    // Pack slots into the record, word k at the k-th WORD_WIDTH field.
    always_comb begin
        ray_data = '0;
        for (int k = 0; k < WORDS_PER_RAY; k++) begin
            ray_data[k*WORD_WIDTH +: WORD_WIDTH] = slots[k];
        end
    end

    assign ray_valid = (state == HOLD);
    assign busy      = (state == HOLD) | (issue_cnt != '0);

endmodule

// File: tb/tb_ray_word_assembler.sv
// tb_ray_word_assembler
// Drives the assembler from a registered-output FIFO model. Popped words are
// grouped into expected records, N at a time, and each record is checked when
// it transfers. A second instance with a 2-bit id shares the stimulus, so the
// id wrap can be observed.
`timescale 1ns/1ps
module tb_ray_word_assembler;
    localparam int W   = 32;
    localparam int N   = 6;
    localparam int IDW = 16;
    localparam int RW  = N * W;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic [W-1:0]   fifo_dout = '0;
    logic           ray_valid;
    logic           ray_ready = 1'b0;
    logic [RW-1:0]  ray_data;
    logic [IDW-1:0] ray_id;
    logic           busy;
    logic           rd_en2, valid2, busy2;
    logic [RW-1:0]  data2;
    logic [1:0]     id2;

    int total = 0;
    int bad = 0;

    // FIFO model state
    logic [W-1:0] fifo_q[$];
    int           push_cnt = 0;
    int           pop_cnt = 0;
    logic         force_empty = 1'b0;
    assign fifo_empty = (push_cnt == pop_cnt) | force_empty;

    // reference model: popped words grouped into records
    logic [W-1:0]   words[$];
    logic [RW-1:0]  exp_q[$];
    logic [IDW-1:0] exp_id_q[$];
    logic [IDW-1:0] model_id = '0;
    logic [W-1:0]   pop_w;
    logic [RW-1:0]  rec;

    // monitor state
    logic           prev_valid = 1'b0;
    logic           prev_xfer = 1'b0;
    logic [RW-1:0]  prev_data = '0;
    logic [IDW-1:0] prev_id = '0;
    logic [RW-1:0]  e_data;
    logic [IDW-1:0] e_id;
    int             xfer_cnt = 0;
    logic [1:0]     id2_log[$];

    ray_word_assembler #(.WORD_WIDTH(W), .WORDS_PER_RAY(N), .ID_WIDTH(IDW)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_data(ray_data), .ray_id(ray_id), .busy(busy)
    );

    ray_word_assembler #(.WORD_WIDTH(W), .WORDS_PER_RAY(N), .ID_WIDTH(2)) dut_id2 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en2),
        .fifo_dout(fifo_dout), .ray_valid(valid2), .ray_ready(ray_ready),
        .ray_data(data2), .ray_id(id2), .busy(busy2)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        push_cnt++;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (k < 300 && !(exp_q.size() == 0 && words.size() == 0 && !busy &&
                            !ray_valid && push_cnt == pop_cnt)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, RW'(k < 300), RW'(1));
    endtask

    task automatic wait_xfer(input string tag, input int target);
        int k = 0;
        while (k < 300 && xfer_cnt < target) begin
            @(negedge clk);
            k++;
        end
        chk(tag, RW'(xfer_cnt >= target), RW'(1));
    endtask

    task automatic measure(input int n, output logic [31:0] rd_v, output logic [31:0] va_v);
        rd_v = '0;
        va_v = '0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) begin
                @(negedge clk);
                #1;
            end
            rd_v[k] = fifo_rd_en;
            va_v[k] = ray_valid;
        end
    endtask

    // FIFO with registered dout; shares the DUT reset; builds expected records
    always @(posedge clk) begin
        if (!reset) begin
            fifo_q.delete();
            words.delete();
            exp_q.delete();
            exp_id_q.delete();
            model_id = '0;
            pop_cnt <= push_cnt;
        end else if (fifo_rd_en) begin
            chk("rd_when_fifo_empty", RW'(fifo_q.size() == 0), RW'(0));
            if (fifo_q.size() != 0) begin
                pop_w = fifo_q.pop_front();
                fifo_dout <= pop_w;
                pop_cnt <= pop_cnt + 1;
                words.push_back(pop_w);
                if (words.size() == N) begin
                    rec = '0;
                    for (int k = 0; k < N; k++) rec[k*W +: W] = words[k];
                    exp_q.push_back(rec);
                    exp_id_q.push_back(model_id);
                    model_id = model_id + 1'b1;
                    words.delete();
                end
            end
        end
    end

    // scoreboard / protocol monitor, sampled just before each posedge
    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (fifo_empty) chk("rd_while_empty", RW'(fifo_rd_en), RW'(0));
            if (ray_valid) begin
                chk("rd_in_hold", RW'(fifo_rd_en), RW'(0));
                chk("busy_in_hold", RW'(busy), RW'(1));
            end
            if (prev_valid && !prev_xfer) begin
                chk("valid_held", RW'(ray_valid), RW'(1));
                chk("data_stable", ray_data, prev_data);
                chk("id_stable", RW'(ray_id), RW'(prev_id));
            end
            if (ray_valid && ray_ready) begin
                chk("record_expected", RW'(exp_q.size() != 0), RW'(1));
                if (exp_q.size() != 0) begin
                    e_data = exp_q.pop_front();
                    e_id   = exp_id_q.pop_front();
                    chk("ray_data", ray_data, e_data);
                    chk("ray_id", RW'(ray_id), RW'(e_id));
                    chk("id2_valid", RW'(valid2), RW'(1));
                    chk("id2_ray_id", RW'(id2), RW'(e_id[1:0]));
                    chk("id2_ray_data", data2, e_data);
                end
                id2_log.push_back(id2);
                xfer_cnt++;
            end
            prev_valid = ray_valid;
            prev_xfer  = ray_valid & ray_ready;
            prev_data  = ray_data;
            prev_id    = ray_id;
        end
    end

    initial begin
        logic [31:0] rd_v, va_v;
        int base, cnt, k;
        logic [1:0] exp_seq [5];
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
        exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;

        // reset state, with a word waiting so the rd_en gate is exercised
        reset = 1'b0;
        repeat (3) @(negedge clk);
        push(32'hEE);
        #1;
        chk("reset_valid", RW'(ray_valid), RW'(0));
        chk("reset_data", ray_data, RW'(0));
        chk("reset_id", RW'(ray_id), RW'(0));
        chk("reset_busy", RW'(busy), RW'(0));
        chk("reset_rd_gate", RW'(fifo_rd_en), RW'(0));
        @(negedge clk);
        reset = 1'b1;

        // T1: six words, ready high: latency pattern
        @(negedge clk);
        ray_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(W'(32'h11 + i));
        #1;
        measure(10, rd_v, va_v);
        chk("t1_rd_cycles", RW'(rd_v), RW'(32'h0000_003F));
        chk("t1_valid_cycles", RW'(va_v), RW'(32'h0000_0080));
        wait_idle("t1_idle");

        // T2: backpressure for 10 cycles with more words waiting
        @(negedge clk);
        ray_ready = 1'b0;
        base = xfer_cnt;
        for (int i = 0; i < 6; i++) push(W'(32'h31 + i));
        k = 0;
        while (!ray_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t2_valid_rise", RW'(ray_valid), RW'(1));
        for (int i = 0; i < 6; i++) push(W'(32'h41 + i));
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en) cnt++;
            chk("t2_valid_held", RW'(ray_valid), RW'(1));
        end
        chk("t2_no_rd_in_hold", RW'(cnt), RW'(0));
        chk("t2_no_xfer_unready", RW'(xfer_cnt - base), RW'(0));
        chk("t2_busy_held", RW'(busy), RW'(1));
        ray_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t2_one_xfer", RW'(xfer_cnt - base), RW'(1));
        chk("t2_valid_drop", RW'(ray_valid), RW'(0));
        chk("t2_id_incr", RW'(ray_id), RW'(2));
        wait_idle("t2_idle");

        // T3: empty flag toggles every two cycles
        @(negedge clk);
        base = xfer_cnt;
        for (int i = 0; i < 6; i++) push(W'(32'hA0 + i));
        cnt = 0;
        k = 0;
        while (xfer_cnt == base && k < 100) begin
            force_empty = (((k >> 1) & 1) == 0);
            #1;
            if (fifo_rd_en) cnt++;
            @(negedge clk);
            k++;
        end
        force_empty = 1'b0;
        chk("t3_xfer", RW'(xfer_cnt - base), RW'(1));
        chk("t3_rd_count", RW'(cnt), RW'(6));
        wait_idle("t3_idle");

        // T4: twelve words back to back
        @(negedge clk);
        for (int i = 0; i < 12; i++) push(W'(i));
        #1;
        measure(18, rd_v, va_v);
        chk("t4_rd_cycles", RW'(rd_v), RW'(32'h0000_3F3F));
        chk("t4_valid_cycles", RW'(va_v), RW'(32'h0000_8080));
        wait_idle("t4_idle");

        // T5: reset after three captures, then a fresh record
        @(negedge clk);
        for (int i = 0; i < 6; i++) push(W'(32'hC0 + i));
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_rd_gated", RW'(fifo_rd_en), RW'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_valid", RW'(ray_valid), RW'(0));
        chk("t5_data", ray_data, RW'(0));
        chk("t5_id", RW'(ray_id), RW'(0));
        chk("t5_busy", RW'(busy), RW'(0));
        chk("t5_rd_flushed", RW'(fifo_rd_en), RW'(0));
        base = xfer_cnt;
        for (int i = 0; i < 6; i++) push(W'(32'hB0 + i));
        wait_xfer("t5_xfer", base + 1);
        wait_idle("t5_idle");

        // T6: random stream of five records, 2-bit id wraps
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        id2_log.delete();
        base = xfer_cnt;
        for (int i = 0; i < 5 * N; i++) push(W'($urandom));
        k = 0;
        while (xfer_cnt - base < 5 && k < 3000) begin
            ray_ready   = ($urandom_range(0, 1) == 1);
            force_empty = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            k++;
        end
        force_empty = 1'b0;
        ray_ready = 1'b1;
        chk("t6_xfer_count", RW'(id2_log.size()), RW'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < id2_log.size()) chk("t6_id2_seq", RW'(id2_log[i]), RW'(exp_seq[i]));
        end
        wait_idle("t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
